// File: rtl/sr_drive_ctrl_if.sv
// Signal bundle between the SR-latch drive controller and its surroundings.
//   set_req, clr_req : asynchronous level requests (into the controller)
//   q_fb             : q fed back from the downstream SR latch
//   s, r             : registered set/reset drives to the latch
//   busy             : controller is producing a pulse or its dead time
//   shadow           : expected latch state
//   err              : sticky feedback-mismatch flag
interface sr_drive_ctrl_if;
    logic set_req;
    logic clr_req;
    logic q_fb;
    logic s;
    logic r;
    logic busy;
    logic shadow;
    logic err;

    modport master (
        output set_req, clr_req, q_fb,
        input  s, r, busy, shadow, err
    );

    modport slave (
        input  set_req, clr_req, q_fb,
        output s, r, busy, shadow, err
    );
endinterface

// File: rtl/sr_drive_ctrl.sv
// Drives the s/r inputs of a downstream SR latch from two asynchronous,
// debounced request lines. Each accepted request becomes one fixed-width
// pulse on s or r, followed by a dead gap; s and r are never high together.
// The expected latch state (shadow) is checked against q_fb at gap end.
//   clk : sole clock, rising edge
//   rst : synchronous, active-high reset
//   bus : sr_drive_ctrl_if slave modport (requests, feedback, drives, status)
//
// state | meaning
// IDLE  | waiting; consumes one pending request per cycle, clear first
// SET_P | s held high for PULSE_W cycles
// CLR_P | r held high for PULSE_W cycles
// GAP   | s=r=0 for GAP_W cycles; q_fb checked on the last one
module sr_drive_ctrl #(
    parameter int DEB_CYCLES = 4,
    parameter int PULSE_W    = 3,
    parameter int GAP_W      = 2
) (
    input  logic           clk,
    input  logic           rst,
    sr_drive_ctrl_if.slave bus
);
    localparam int DW   = $clog2(DEB_CYCLES + 1);
    localparam int CMAX = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYCLES - 1);
    localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_W - 1);
    localparam logic [CW-1:0] GAP_LOAD   = CW'(GAP_W - 1);

    typedef enum logic [1:0] {IDLE, SET_P, CLR_P, GAP} state_t;

    // Index 0 is the set path, index 1 the clear path.
    logic [1:0]    req;
    logic [1:0]    sync1, sync2, dbl, dbl_d, pend, consume;
    logic [DW-1:0] deb_cnt [2];

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          shadow, shadow_nxt, err, err_nxt;
    logic          s_q, r_q;

    assign req = {bus.clr_req, bus.set_req};

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            dbl   <= '0;
            dbl_d <= '0;
            for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
        end else begin
            sync1 <= req;
            sync2 <= sync1;
            dbl_d <= dbl;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] != dbl[i]) begin
                    if (deb_cnt[i] == DEB_LAST) begin
                        dbl[i]     <= ~dbl[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + 1'b1;
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    // A new rising edge wins over a same-cycle consume, so it is never lost.
    always_ff @(posedge clk) begin
        if (rst) pend <= '0;
        else     pend <= (pend & ~consume) | (dbl & ~dbl_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            shadow <= 1'b0;
            err    <= 1'b0;
            s_q    <= 1'b0;
            r_q    <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            shadow <= shadow_nxt;
            err    <= err_nxt;
            s_q    <= (state_nxt == SET_P);
            r_q    <= (state_nxt == CLR_P);
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        consume    = '0;
        shadow_nxt = shadow;
        err_nxt    = err;
        case (state)
            IDLE: begin
                // Requests that would not change the latch are dropped.
                if (pend[1]) begin
                    consume[1] = 1'b1;
                    if (shadow) begin
                        state_nxt = CLR_P;
                        cnt_nxt   = PULSE_LOAD;
                    end
                end else if (pend[0]) begin
                    consume[0] = 1'b1;
                    if (!shadow) begin
                        state_nxt = SET_P;
                        cnt_nxt   = PULSE_LOAD;
                    end
                end
            end
            SET_P, CLR_P: begin
                if (cnt == '0) begin
                    shadow_nxt = (state == SET_P);
                    state_nxt  = GAP;
                    cnt_nxt    = GAP_LOAD;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            GAP: begin
                if (cnt == '0) begin
                    if (bus.q_fb != shadow) err_nxt = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.s      = s_q;
    assign bus.r      = r_q;
    assign bus.busy   = (state != IDLE);
    assign bus.shadow = shadow;
    assign bus.err    = err;
endmodule

// File: tb/tb_sr_drive_ctrl.sv
// Directed bench for sr_drive_ctrl with default parameters (4/3/2).
// A clocked latch model feeds q_fb unless fb_force overrides it.
module tb_sr_drive_ctrl;
    logic clk = 1'b0;
    logic rst;
    logic fb_force, fb_val;
    logic latch_q = 1'b0;

    int tests = 0;
    int fails = 0;

    int cyc = 0;
    int s_rises = 0, r_rises = 0, busy_cycles = 0;
    int s_rise_cyc = 0, r_rise_cyc = 0;
    int overlap_cnt = 0;
    bit s_prev = 1'b0, r_prev = 1'b0;

    sr_drive_ctrl_if bif();

    sr_drive_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    always #5 clk = ~clk;

    assign bif.q_fb = fb_force ? fb_val : latch_q;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bif.s === 1'b1)      latch_q <= 1'b1;
        else if (bif.r === 1'b1) latch_q <= 1'b0;
    end

    always @(negedge clk) begin
        if (bif.s === 1'b1 && !s_prev) begin s_rises++; s_rise_cyc = cyc; end
        if (bif.r === 1'b1 && !r_prev) begin r_rises++; r_rise_cyc = cyc; end
        if (bif.busy === 1'b1) busy_cycles++;
        if (bif.s === 1'b1 && bif.r === 1'b1) overlap_cnt++;
        s_prev = (bif.s === 1'b1);
        r_prev = (bif.r === 1'b1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    // Request rises before edge E0; pulse expected after E0+7.
    task automatic pulse_seq(input bit is_set, input bit err_before, input bit err_after);
        if (is_set) bif.set_req = 1'b1;
        else        bif.clr_req = 1'b1;
        ticks(7);
        chk("pre_s", bif.s, 0);
        chk("pre_r", bif.r, 0);
        chk("pre_busy", bif.busy, 0);
        tick();
        chk("pulse_on", is_set ? bif.s : bif.r, 1);
        chk("pulse_other", is_set ? bif.r : bif.s, 0);
        chk("busy_on", bif.busy, 1);
        bif.set_req = 1'b0;
        bif.clr_req = 1'b0;
        ticks(2);
        chk("pulse_hold", is_set ? bif.s : bif.r, 1);
        tick();
        chk("pulse_off", bif.s | bif.r, 0);
        chk("shadow", bif.shadow, is_set);
        chk("busy_gap", bif.busy, 1);
        chk("err_gap", bif.err, err_before);
        ticks(2);
        chk("busy_done", bif.busy, 0);
        chk("err_done", bif.err, err_after);
    endtask

    initial begin
        int s0, r0, b0;
        rst = 1'b1;
        bif.set_req = 1'b1;
        bif.clr_req = 1'b0;
        fb_force = 1'b0;
        fb_val = 1'b0;

        // reset with set_req held high
        tick();
        chk("rst_s", bif.s, 0);
        chk("rst_r", bif.r, 0);
        chk("rst_busy", bif.busy, 0);
        chk("rst_shadow", bif.shadow, 0);
        chk("rst_err", bif.err, 0);
        tick();
        chk("rst2_s", bif.s, 0);
        chk("rst2_busy", bif.busy, 0);
        rst = 1'b0;
        pulse_seq(1'b1, 1'b0, 1'b0);
        ticks(8);

        // clear after set
        pulse_seq(1'b0, 1'b0, 1'b0);
        ticks(8);
        chk("no_overlap_a", overlap_cnt, 0);

        // glitch of 2 cycles is filtered
        s0 = s_rises; b0 = busy_cycles;
        bif.set_req = 1'b1;
        ticks(2);
        bif.set_req = 1'b0;
        ticks(20);
        chk("glitch_s_pulses", s_rises - s0, 0);
        chk("glitch_busy", busy_cycles - b0, 0);

        // 6-cycle request gives exactly one pulse
        s0 = s_rises;
        bif.set_req = 1'b1;
        ticks(6);
        bif.set_req = 1'b0;
        ticks(20);
        chk("wide_s_pulses", s_rises - s0, 1);
        chk("wide_shadow", bif.shadow, 1);

        // simultaneous requests with shadow=1: clear first, then set
        s0 = s_rises; r0 = r_rises;
        bif.set_req = 1'b1;
        bif.clr_req = 1'b1;
        ticks(8);
        chk("simul_r_first", bif.r, 1);
        chk("simul_s_not_yet", bif.s, 0);
        bif.set_req = 1'b0;
        bif.clr_req = 1'b0;
        ticks(20);
        chk("simul_r_pulses", r_rises - r0, 1);
        chk("simul_s_pulses", s_rises - s0, 1);
        chk("simul_spacing", s_rise_cyc - r_rise_cyc, 6);
        chk("simul_shadow", bif.shadow, 1);

        // redundant set with shadow=1
        s0 = s_rises; b0 = busy_cycles;
        bif.set_req = 1'b1;
        ticks(8);
        bif.set_req = 1'b0;
        ticks(15);
        chk("redund_s_pulses", s_rises - s0, 0);
        chk("redund_busy", busy_cycles - b0, 0);

        // three set edges in quick succession from shadow=0
        pulse_seq(1'b0, 1'b0, 1'b0);
        ticks(8);
        s0 = s_rises;
        repeat (3) begin
            bif.set_req = 1'b1;
            ticks(5);
            bif.set_req = 1'b0;
            ticks(5);
        end
        ticks(20);
        chk("collapse_s_pulses", s_rises - s0, 1);
        chk("collapse_shadow", bif.shadow, 1);

        // feedback mismatch sets sticky err
        pulse_seq(1'b0, 1'b0, 1'b0);
        ticks(8);
        fb_force = 1'b1;
        fb_val = 1'b0;
        pulse_seq(1'b1, 1'b0, 1'b1);
        fb_force = 1'b0;
        ticks(5);
        chk("err_sticky", bif.err, 1);

        // reset on s cycle 2 truncates the pulse
        pulse_seq(1'b0, 1'b1, 1'b1);
        ticks(8);
        s0 = s_rises;
        bif.set_req = 1'b1;
        ticks(8);
        chk("midrst_s_c1", bif.s, 1);
        tick();
        chk("midrst_s_c2", bif.s, 1);
        rst = 1'b1;
        bif.set_req = 1'b0;
        tick();
        chk("midrst_s", bif.s, 0);
        chk("midrst_err", bif.err, 0);
        chk("midrst_shadow", bif.shadow, 0);
        chk("midrst_busy", bif.busy, 0);
        tick();
        rst = 1'b0;
        ticks(12);
        chk("midrst_no_resume", s_rises - s0, 1);
        chk("midrst_idle", bif.busy, 0);
        chk("no_overlap_b", overlap_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
